// File: rtl/nec_prefetch_pkg.sv
// Shared types for the NEC core front end: prefetch FSM states, the queue
// storage type and the segment:offset to physical address helper.
package nec_prefetch_pkg;

    localparam int PF_QUEUE_BYTES = 8;
    localparam int PF_ADDR_WIDTH  = 20;

    typedef enum logic {
        PF_IDLE,
        PF_REQ
    } prefetch_state_e;

    typedef logic [PF_QUEUE_BYTES-1:0][7:0] ipq_t;

    // Word-aligned physical address of the bus word holding byte 'off' in segment 'seg'.
    function automatic logic [PF_ADDR_WIDTH-1:0] fetch_addr(input logic [15:0] seg,
                                                            input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/nec_prefetch.sv
// Instruction prefetch unit: fetches code words at PS:fetch_pc into an 8-byte
// circular queue indexed by the low three bits of the absolute byte offset.
module nec_prefetch
    import nec_prefetch_pkg::*;
#(
    parameter int QUEUE_BYTES = 8,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic [15:0]                 ps,
    input  logic [15:0]                 decode_pc,
    input  logic                        flush,
    input  logic [15:0]                 new_pc,
    input  logic                        suspend,
    output logic                        bus_req,
    output logic [ADDR_WIDTH-1:0]       bus_addr,
    input  logic                        bus_ack,
    input  logic [15:0]                 bus_data,
    output logic [QUEUE_BYTES-1:0][7:0] ipq,
    output logic [3:0]                  ipq_len,
    output logic [15:0]                 fetch_pc
);

    prefetch_state_e state, state_next;
    logic            discard;
    logic [15:0]     occupancy;
    logic [3:0]      free_bytes;
    logic            space_ok;
    logic            start_req;
    logic            ack_accept;
    logic [2:0]      slot_lo;
    logic [2:0]      slot_hi;

    assign occupancy  = fetch_pc - decode_pc;
    assign ipq_len    = occupancy[3:0];
    assign free_bytes = 4'd8 - ipq_len;
    // An odd fetch_pc only needs room for the single high byte of its word.
    assign space_ok   = fetch_pc[0] ? (free_bytes >= 4'd1) : (free_bytes >= 4'd2);
    assign ack_accept = ce && (state == PF_REQ) && bus_ack;
    assign bus_req    = (state == PF_REQ);
    assign slot_lo    = fetch_pc[2:0];
    assign slot_hi    = slot_lo + 3'd1;

    always_comb begin
        state_next = state;
        start_req  = 1'b0;
        case (state)
            PF_IDLE: begin
                if (ce && !suspend && !flush && space_ok) begin
                    state_next = PF_REQ;
                    start_req  = 1'b1;
                end
            end
            PF_REQ: begin
                if (ack_accept) begin
                    state_next = PF_IDLE;
                end
            end
            default: state_next = PF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PF_IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // A flush cannot abort a bus cycle in flight, so its data is marked for discard instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= 16'h0000;
            discard  <= 1'b0;
            bus_addr <= '0;
            ipq      <= '0;
        end else if (ce) begin
            if (start_req) begin
                bus_addr <= fetch_addr(ps, fetch_pc);
            end
            if (flush) begin
                fetch_pc <= new_pc;
                discard  <= (state == PF_REQ) && !bus_ack;
            end else if (ack_accept) begin
                discard <= 1'b0;
                if (!discard) begin
                    if (fetch_pc[0]) begin
                        ipq[slot_lo] <= bus_data[15:8];
                        fetch_pc     <= fetch_pc + 16'd1;
                    end else begin
                        ipq[slot_lo] <= bus_data[7:0];
                        ipq[slot_hi] <= bus_data[15:8];
                        fetch_pc     <= fetch_pc + 16'd2;
                    end
                end
            end
        end
    end

    a_len_bound: assert property (@(posedge clk) disable iff (reset) occupancy <= 16'd8);

endmodule

// File: tb/tb_nec_prefetch.sv
// Self-checking bench for nec_prefetch: directed scenarios plus a randomized run
// checked against a byte-addressed memory model of the code segment.
module tb_nec_prefetch;
    import nec_prefetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset, ce, flush, suspend, bus_ack, bus_req;
    logic [15:0] ps, decode_pc, new_pc, bus_data, fetch_pc;
    logic [19:0] bus_addr;
    ipq_t        ipq;
    logic [3:0]  ipq_len;

    int          checks = 0;
    int          errors = 0;
    int          ack_lat, wait_cnt, ack_cnt, req_cnt;
    logic        last_accept, req_pre, fixed_en;
    logic [15:0] fixed_data;
    logic [31:0] seed;
    logic [19:0] addr_log[$];

    nec_prefetch #(.QUEUE_BYTES(8), .ADDR_WIDTH(20)) dut (
        .clk(clk), .reset(reset), .ce(ce), .ps(ps), .decode_pc(decode_pc),
        .flush(flush), .new_pc(new_pc), .suspend(suspend), .bus_req(bus_req),
        .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_data(bus_data),
        .ipq(ipq), .ipq_len(ipq_len), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Code memory contents as a pure function of the physical word address.
    function automatic logic [15:0] mem_word(input logic [19:0] a);
        logic [31:0] h;
        h = ({12'b0, a} ^ seed) * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return h[15:0] ^ h[31:16];
    endfunction

    function automatic logic [7:0] mem_byte(input logic [15:0] seg, input logic [15:0] off);
        logic [19:0] pa;
        logic [15:0] w;
        pa = {seg, 4'b0000} + {4'b0000, off};
        w  = mem_word({pa[19:1], 1'b0});
        return pa[0] ? w[15:8] : w[7:0];
    endfunction

    // One clock: the bus responder acks after ack_lat request cycles.
    task automatic cycle();
        logic acc;
        bus_ack  = 1'b0;
        bus_data = 16'($urandom);
        if (bus_req && wait_cnt >= ack_lat) begin
            bus_ack  = 1'b1;
            bus_data = fixed_en ? fixed_data : mem_word(bus_addr);
        end
        acc     = bus_ack && ce && !reset;
        req_pre = bus_req;
        if (acc || !bus_req || reset) wait_cnt = 0;
        else if (ce) wait_cnt++;
        @(posedge clk);
        #1;
        last_accept = acc;
        if (acc) ack_cnt++;
        if (bus_req && !req_pre) begin
            req_cnt++;
            addr_log.push_back(bus_addr);
        end
        bus_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; ce = 1'b1; flush = 1'b0; suspend = 1'b0;
        decode_pc = 16'h0000; new_pc = 16'h0000; fixed_en = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        wait_cnt = 0; ack_cnt = 0; req_cnt = 0;
        addr_log.delete();
    endtask

    // The decoder loads new_pc on the same edge that the prefetcher sees flush.
    task automatic do_flush(input logic [15:0] pc);
        flush = 1'b1; new_pc = pc;
        cycle();
        flush = 1'b0; decode_pc = pc;
        #1;
    endtask

    task automatic wait_acks(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && ack_cnt < target; i++) cycle();
        ok = (ack_cnt >= target);
    endtask

    task automatic wait_reqs(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && req_cnt < target; i++) cycle();
        ok = (req_cnt >= target);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_req: got %0h, expected 0", bus_req); end
        checks++; if (fetch_pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_fetch_pc: got %h, expected 0000", fetch_pc); end
        checks++; if (ipq_len !== 4'd0) begin errors++; $display("[TB] FAIL reset_ipq_len: got %0d, expected 0", ipq_len); end
        checks++; if (ipq !== '0) begin errors++; $display("[TB] FAIL reset_ipq: got %h, expected 0", ipq); end
    endtask

    task automatic test_fill_even();
        logic [19:0] exp_addr [4] = '{20'h10100, 20'h10102, 20'h10104, 20'h10106};
        int          lens[$];
        int          bad;
        do_reset();
        ps = 16'h1000; ack_lat = 1;
        do_flush(16'h0100);
        checks++; if (ipq_len !== 4'd0) begin errors++; $display("[TB] FAIL fill_len_after_flush: got %0d, expected 0", ipq_len); end
        for (int i = 0; i < 60 && lens.size() < 4; i++) begin
            cycle();
            if (last_accept) lens.push_back(int'(ipq_len));
        end
        checks++;
        if (lens.size() != 4 || addr_log.size() != 4) begin
            errors++; $display("[TB] FAIL fill_count: got %0d acks %0d reqs, expected 4 and 4", lens.size(), addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (addr_log[i] !== exp_addr[i]) begin errors++; $display("[TB] FAIL fill_addr%0d: got %h, expected %h", i, addr_log[i], exp_addr[i]); end
                checks++; if (lens[i] != 2 * (i + 1)) begin errors++; $display("[TB] FAIL fill_len%0d: got %0d, expected %0d", i, lens[i], 2 * (i + 1)); end
            end
        end
        repeat (10) cycle();
        checks++; if (req_cnt != 4 || bus_req !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_req_when_full: got %0d reqs, expected 4", req_cnt); end
        checks++; if (fetch_pc !== 16'h0108) begin errors++; $display("[TB] FAIL fill_fetch_pc: got %h, expected 0108", fetch_pc); end
        bad = 0;
        for (int n = 0; n < 8; n++) if (ipq[3'(n)] !== mem_byte(ps, 16'h0100 + 16'(n))) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fill_contents: got %0d bad bytes, expected 0", bad); end
    endtask

    task automatic test_consumption();
        bit ok;
        decode_pc = 16'h0103;
        #1;
        checks++; if (ipq_len !== 4'd5) begin errors++; $display("[TB] FAIL consume_len: got %0d, expected 5", ipq_len); end
        wait_acks(ack_cnt + 1, 20, ok);
        checks++; if (!ok || addr_log.size() != 5 || addr_log[addr_log.size()-1] !== 20'h10108) begin
            errors++; $display("[TB] FAIL consume_refill_addr: got %0d reqs last %h, expected 5 last 10108", addr_log.size(), bus_addr);
        end
        checks++; if (ipq_len !== 4'd7) begin errors++; $display("[TB] FAIL consume_len_after: got %0d, expected 7", ipq_len); end
        checks++; if (ipq[0] !== mem_byte(ps, 16'h0108) || ipq[1] !== mem_byte(ps, 16'h0109)) begin
            errors++; $display("[TB] FAIL consume_overwrite: got %h%h, expected %h%h", ipq[1], ipq[0], mem_byte(ps, 16'h0109), mem_byte(ps, 16'h0108));
        end
        repeat (10) cycle();
        checks++; if (req_cnt != 5) begin errors++; $display("[TB] FAIL consume_no_req: got %0d reqs, expected 5", req_cnt); end
    endtask

    task automatic test_odd_start();
        bit ok;
        do_reset();
        ps = 16'h1000; ack_lat = 1; fixed_en = 1'b1; fixed_data = 16'hBBAA;
        do_flush(16'h0101);
        wait_acks(1, 20, ok);
        suspend = 1'b1;
        checks++; if (!ok || addr_log.size() < 1 || addr_log[0] !== 20'h10100) begin errors++; $display("[TB] FAIL odd_addr: got %h, expected 10100", bus_addr); end
        checks++; if (ipq[1] !== 8'hBB) begin errors++; $display("[TB] FAIL odd_byte: got %h, expected bb", ipq[1]); end
        checks++; if (fetch_pc !== 16'h0102) begin errors++; $display("[TB] FAIL odd_fetch_pc: got %h, expected 0102", fetch_pc); end
        checks++; if (ipq_len !== 4'd1) begin errors++; $display("[TB] FAIL odd_len: got %0d, expected 1", ipq_len); end
        repeat (3) cycle();
        checks++; if (req_cnt != 1) begin errors++; $display("[TB] FAIL odd_suspend: got %0d reqs, expected 1", req_cnt); end
        fixed_en = 1'b0; suspend = 1'b0;
    endtask

    task automatic test_flush_mid();
        bit   ok;
        ipq_t snap;
        do_reset();
        ps = 16'h1000; ack_lat = 1;
        do_flush(16'h0100);
        wait_reqs(3, 30, ok);
        checks++; if (!ok || bus_addr !== 20'h10104) begin errors++; $display("[TB] FAIL flushmid_setup: got %h, expected 10104", bus_addr); end
        ack_lat = 3; fixed_en = 1'b1; fixed_data = 16'hDEAD; snap = ipq;
        do_flush(16'h2000);
        checks++; if (ipq_len !== 4'd0) begin errors++; $display("[TB] FAIL flushmid_len: got %0d, expected 0", ipq_len); end
        checks++; if (bus_req !== 1'b1 || bus_addr !== 20'h10104) begin errors++; $display("[TB] FAIL flushmid_hold: got %0h/%h, expected 1/10104", bus_req, bus_addr); end
        wait_acks(ack_cnt + 1, 10, ok);
        checks++; if (!ok || ipq !== snap) begin errors++; $display("[TB] FAIL flushmid_dropped: got %h, expected %h", ipq, snap); end
        checks++; if (fetch_pc !== 16'h2000 || ipq_len !== 4'd0) begin errors++; $display("[TB] FAIL flushmid_pc: got %h len %0d, expected 2000 len 0", fetch_pc, ipq_len); end
        fixed_en = 1'b0;
        wait_reqs(req_cnt + 1, 10, ok);
        checks++; if (!ok || addr_log[addr_log.size()-1] !== 20'h12000) begin errors++; $display("[TB] FAIL flushmid_next_addr: got %h, expected 12000", bus_addr); end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        do_reset();
        ps = 16'hF000; ack_lat = 1;
        do_flush(16'hFFFE);
        wait_acks(2, 30, ok);
        suspend = 1'b1;
        checks++; if (!ok || addr_log.size() < 2) begin errors++; $display("[TB] FAIL wrap_acks: got %0d, expected 2", ack_cnt); end
        else begin
            checks++; if (addr_log[0] !== 20'hFFFFE) begin errors++; $display("[TB] FAIL wrap_addr0: got %h, expected ffffe", addr_log[0]); end
            checks++; if (addr_log[1] !== 20'hF0000) begin errors++; $display("[TB] FAIL wrap_addr1: got %h, expected f0000", addr_log[1]); end
        end
        checks++; if (fetch_pc !== 16'h0002 || ipq_len !== 4'd4) begin errors++; $display("[TB] FAIL wrap_pc_len: got %h/%0d, expected 0002/4", fetch_pc, ipq_len); end
        bad = 0;
        for (int n = 0; n < 4; n++) if (ipq[3'(6 + n)] !== mem_byte(ps, 16'hFFFE + 16'(n))) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL wrap_contents: got %0d bad bytes, expected 0", bad); end
        suspend = 1'b0;
    endtask

    task automatic test_suspend_ce();
        bit          ok;
        logic [57:0] snap;
        do_reset();
        ps = 16'h1000; ack_lat = 2;
        do_flush(16'h0200);
        wait_reqs(1, 10, ok);
        suspend = 1'b1;
        wait_acks(1, 10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL suspend_complete: got %0d acks, expected 1", ack_cnt); end
        repeat (10) cycle();
        checks++; if (req_cnt != 1 || bus_req !== 1'b0 || fetch_pc !== 16'h0202) begin
            errors++; $display("[TB] FAIL suspend_block: got %0d reqs pc %h, expected 1 reqs pc 0202", req_cnt, fetch_pc);
        end
        suspend = 1'b0;
        wait_reqs(2, 10, ok);
        ack_lat = 0; ce = 1'b0;
        snap = {bus_req, bus_addr, fetch_pc, ipq_len, 17'b0};
        for (int i = 0; i < 5; i++) begin
            logic [63:0] snap_q;
            snap_q = ipq;
            cycle();
            checks++; if ({bus_req, bus_addr, fetch_pc, ipq_len, 17'b0} !== snap || ipq !== snap_q || !ok) begin
                errors++; $display("[TB] FAIL ce_hold%0d: got %0h/%h/%h/%0d, expected %h", i, bus_req, bus_addr, fetch_pc, ipq_len, snap);
            end
        end
        ce = 1'b1;
        wait_acks(2, 5, ok);
        checks++; if (!ok || fetch_pc !== 16'h0204) begin errors++; $display("[TB] FAIL ce_resume: got %h, expected 0204", fetch_pc); end
    endtask

    task automatic test_reset_mid_request();
        bit ok;
        do_reset();
        ps = 16'h1000; ack_lat = 1;
        do_flush(16'h0300);
        wait_reqs(3, 30, ok);
        reset = 1'b1; decode_pc = 16'h0000;
        cycle();
        checks++; if (!ok || bus_req !== 1'b0 || fetch_pc !== 16'h0000 || ipq_len !== 4'd0 || ipq !== '0) begin
            errors++; $display("[TB] FAIL reset_mid: got req %0h pc %h len %0d ipq %h, expected all zero", bus_req, fetch_pc, ipq_len, ipq);
        end
        reset = 1'b0; wait_cnt = 0;
    endtask

    task automatic test_random();
        logic [15:0] mfp, dlen;
        logic [19:0] pa, held;
        bit          stale, fl;
        int          bad, rq;
        do_reset();
        ps = 16'($urandom); ack_lat = 1;
        mfp = 16'($urandom);
        do_flush(mfp);
        stale = 1'b0; held = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ce      = ($urandom_range(0, 9) != 0);
            suspend = ($urandom_range(0, 9) == 0);
            fl      = ce && ($urandom_range(0, 29) == 0);
            dlen    = mfp - decode_pc;
            if (fl) begin
                flush = 1'b1; new_pc = 16'($urandom);
            end else if ($urandom_range(0, 2) == 0) begin
                decode_pc = decode_pc + 16'($urandom_range(0, int'(dlen)));
            end
            rq = req_cnt;
            cycle();
            if (fl) begin
                stale = req_pre && !last_accept;
                mfp = new_pc; flush = 1'b0; decode_pc = new_pc;
            end else if (last_accept) begin
                if (stale) stale = 1'b0;
                else mfp = mfp + (mfp[0] ? 16'd1 : 16'd2);
            end
            #1;
            dlen = mfp - decode_pc;
            checks++; if (fetch_pc !== mfp) begin errors++; $display("[TB] FAIL rnd_fetch_pc: got %h, expected %h", fetch_pc, mfp); end
            checks++; if (ipq_len !== dlen[3:0] || dlen > 16'd8) begin errors++; $display("[TB] FAIL rnd_len: got %0d, expected %0d", ipq_len, dlen); end
            if (last_accept) begin
                checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rnd_back_to_back: got %0h, expected 0", bus_req); end
            end
            if (req_cnt != rq) begin
                ack_lat = $urandom_range(0, 3);
                pa = {ps, 4'b0000} + {4'b0000, mfp};
                pa[0] = 1'b0;
                held = bus_addr;
                checks++; if (bus_addr !== pa) begin errors++; $display("[TB] FAIL rnd_req_addr: got %h, expected %h", bus_addr, pa); end
            end else if (bus_req) begin
                checks++; if (bus_addr !== held) begin errors++; $display("[TB] FAIL rnd_addr_hold: got %h, expected %h", bus_addr, held); end
            end
            bad = 0;
            for (int n = 0; n < 8; n++) begin
                if (16'(n) < dlen && ipq[decode_pc[2:0] + 3'(n)] !== mem_byte(ps, decode_pc + 16'(n))) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rnd_contents: got %0d bad bytes, expected 0", bad); end
        end
        ce = 1'b1; suspend = 1'b0;
    endtask

    initial begin
        seed = $urandom;
        bus_ack = 1'b0; bus_data = 16'h0000; ps = 16'h0000;
        ack_lat = 1; wait_cnt = 0; ack_cnt = 0; req_cnt = 0;
        last_accept = 1'b0; req_pre = 1'b0; fixed_data = 16'h0000;
        test_reset();
        test_fill_even();
        test_consumption();
        test_odd_start();
        test_flush_mid();
        test_wrap();
        test_suspend_ce();
        test_reset_mid_request();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
